// File: rtl/hmr_recovery_sequencer_pkg.sv
// Shared types and defaults for the HMR rapid-recovery sequencer.
// Imported by the sequencer and anything that decodes its state.
package hmr_recovery_sequencer_pkg;

    typedef enum logic [2:0] {
        REC_IDLE,
        REC_HALT,
        REC_RESTORE_CSR,
        REC_RESTORE_PC,
        REC_RESTORE_RF,
        REC_RESUME,
        REC_WAIT_RUN
    } recovery_state_e;

    localparam int unsigned RecoveryHaltTimeout = 255;
    localparam int unsigned RecoveryRfPorts     = 2;

    // Counter width that stays at least one bit for degenerate ranges
    function automatic int unsigned rec_cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/hmr_recovery_sequencer.sv
// Rapid-recovery sequencer: halt masked cores, restore CSR/PC/RF
// from backup over parallel write ports, then resume the cores.
module hmr_recovery_sequencer
    import hmr_recovery_sequencer_pkg::*;
#(
    parameter int unsigned NumCores     = 8,
    parameter int unsigned NumRegs      = 32,
    parameter int unsigned RfWritePorts = RecoveryRfPorts,
    parameter int unsigned AddrWidth    = $clog2(NumRegs),
    parameter int unsigned HaltTimeout  = RecoveryHaltTimeout
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              start_i,
    input  logic [NumCores-1:0]               core_mask_i,
    input  logic [NumCores-1:0]               core_halted_i,
    output logic                              busy_o,
    output logic                              done_o,
    output logic                              timeout_o,
    output logic [NumCores-1:0]               debug_halt_o,
    output logic [NumCores-1:0]               debug_resume_o,
    output logic                              csr_restore_o,
    output logic                              pc_restore_o,
    output logic [RfWritePorts-1:0]           rf_we_o,
    output logic [RfWritePorts*AddrWidth-1:0] rf_addr_o
);

    localparam int unsigned NumSteps = NumRegs / RfWritePorts;
    localparam int unsigned StepW    = rec_cnt_width(NumSteps);
    localparam int unsigned TimerW   = rec_cnt_width(HaltTimeout + 1);

    localparam logic [StepW-1:0]  StepLast  = StepW'(NumSteps - 1);
    localparam logic [TimerW-1:0] TimerLast = TimerW'(HaltTimeout);

    if ((NumRegs % RfWritePorts) != 0) begin : g_regs_check
        $error("NumRegs must be a multiple of RfWritePorts");
    end

    recovery_state_e     state_q, state_d;
    logic [NumCores-1:0] mask_q, mask_d;
    logic [TimerW-1:0]   timer_q, timer_d;
    logic [StepW-1:0]    step_q, step_d;
    logic                done_q, done_d;
    logic                timeout_q, timeout_d;

    logic all_halted;
    logic all_running;

    assign all_halted  = (core_halted_i & mask_q) == mask_q;
    assign all_running = (core_halted_i & mask_q) == '0;

    // State, latched mask, timer, step counter and result pulses
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= REC_IDLE;
            mask_q    <= '0;
            timer_q   <= '0;
            step_q    <= '0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            mask_q    <= mask_d;
            timer_q   <= timer_d;
            step_q    <= step_d;
            done_q    <= done_d;
            timeout_q <= timeout_d;
        end
    end

    // Next-state logic; the timer only runs while waiting on cores
    always_comb begin
        state_d   = state_q;
        mask_d    = mask_q;
        timer_d   = '0;
        step_d    = '0;
        done_d    = 1'b0;
        timeout_d = 1'b0;
        unique case (state_q)
            REC_IDLE: begin
                if (start_i && (|core_mask_i)) begin
                    mask_d  = core_mask_i;
                    state_d = REC_HALT;
                end
            end
            REC_HALT: begin
                if (all_halted) begin
                    state_d = REC_RESTORE_CSR;
                end else if (timer_q == TimerLast) begin
                    state_d   = REC_IDLE;
                    timeout_d = 1'b1;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            REC_RESTORE_CSR: state_d = REC_RESTORE_PC;
            REC_RESTORE_PC:  state_d = REC_RESTORE_RF;
            REC_RESTORE_RF: begin
                if (step_q == StepLast) begin
                    state_d = REC_RESUME;
                end else begin
                    step_d = step_q + 1'b1;
                end
            end
            REC_RESUME: state_d = REC_WAIT_RUN;
            REC_WAIT_RUN: begin
                if (all_running) begin
                    state_d = REC_IDLE;
                    done_d  = 1'b1;
                end else if (timer_q == TimerLast) begin
                    state_d   = REC_IDLE;
                    timeout_d = 1'b1;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: state_d = REC_IDLE;
        endcase
    end

    // Outputs decoded from registered state only
    always_comb begin
        busy_o         = (state_q != REC_IDLE);
        done_o         = done_q;
        timeout_o      = timeout_q;
        debug_halt_o   = '0;
        debug_resume_o = '0;
        csr_restore_o  = 1'b0;
        pc_restore_o   = 1'b0;
        rf_we_o        = '0;
        rf_addr_o      = '0;
        unique case (1'b1)
            (state_q == REC_HALT): begin
                debug_halt_o = mask_q;
            end
            (state_q == REC_RESTORE_CSR): begin
                debug_halt_o  = mask_q;
                csr_restore_o = 1'b1;
            end
            (state_q == REC_RESTORE_PC): begin
                debug_halt_o = mask_q;
                pc_restore_o = 1'b1;
            end
            (state_q == REC_RESTORE_RF): begin
                debug_halt_o = mask_q;
                rf_we_o      = '1;
                for (int p = 0; p < RfWritePorts; p++) begin
                    rf_addr_o[p*AddrWidth +: AddrWidth] =
                        AddrWidth'(int'(step_q) * RfWritePorts + p);
                end
            end
            (state_q == REC_RESUME): begin
                debug_resume_o = mask_q;
            end
            default: ;
        endcase
    end

endmodule

// File: doc/hmr_recovery_sequencer.md
# hmr_recovery_sequencer

Parametrised rapid-recovery sequencer for the HMR unit. On request it halts a selectable group of cluster cores, then restores CSR, PC and register-file state from the backup storage over a configurable number of parallel write ports, and finally resumes the cores. Both halt and resume are bounded by a timeout. It generalises the fixed single-core, single-port backup restore to N cores and P write ports. It sits between the HMR unit's control logic and the cores' debug/recovery inputs.

## Interface
- NumCores, 8: cores that can be recovered.
- NumRegs, 32: register-file entries to restore. Must be a multiple of RfWritePorts.
- RfWritePorts, 2: parallel register-file write ports (1, 2 or 4).
- AddrWidth, $clog2(NumRegs): register address width.
- HaltTimeout, 255: maximum cycles to wait in HALT or WAIT_RUN.

Clock and reset: one clock; reset is synchronous and active-high.
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- start_i  in  1  recovery request; sampled only in IDLE
- core_mask_i  in  NumCores  cores to recover; latched when start is accepted
- core_halted_i  in  NumCores  per-core halted status
- busy_o  out  1  high in every state except IDLE
- done_o  out  1  one-cycle completion pulse
- timeout_o  out  1  one-cycle timeout pulse
- debug_halt_o  out  NumCores  halt request to cores
- debug_resume_o  out  NumCores  resume pulse to cores
- csr_restore_o  out  1  CSR restore strobe
- pc_restore_o  out  1  PC restore strobe
- rf_we_o  out  RfWritePorts  register-file restore write enables
- rf_addr_o  out  RfWritePorts*AddrWidth  addresses; drive both the backup read and the core write

## Operation
- States: IDLE, HALT, RESTORE_CSR, RESTORE_PC, RESTORE_RF, RESUME, WAIT_RUN.
- IDLE: start_i=1 with a non-zero core_mask_i latches the mask into mask_q and moves to HALT. start_i with mask 0 is ignored.
- HALT:
  - debug_halt_o=mask_q.
  - Exits to RESTORE_CSR when (core_halted_i & mask_q)==mask_q.
  - Otherwise the timer increments. When the timer reaches HaltTimeout: timeout_o pulses, the state returns to IDLE, and halt is released. No restore happens and done_o does not pulse.
- RESTORE_CSR and RESTORE_PC: one cycle each. The respective strobe is high, and debug_halt_o stays at mask_q.
- RESTORE_RF:
  - Lasts NumRegs/RfWritePorts cycles, driven by a step counter k = 0..NumRegs/RfWritePorts-1.
  - Port p writes address k*RfWritePorts+p, and rf_we_o is all ones.
  - Address 0 is written like any other entry.
  - debug_halt_o stays at mask_q.
- RESUME: one cycle. debug_halt_o=0 and debug_resume_o=mask_q.
- WAIT_RUN:
  - Exits when (core_halted_i & mask_q)==0. done_o then pulses in the following IDLE cycle.
  - The timer works as in HALT. On expiry, timeout_o pulses and the state goes to IDLE with no done_o.
- The timer is cleared on every state entry.
- start_i while busy is ignored; there is no queueing.
- Cores outside mask_q never see halt, resume or any state change.

## Timing
- All outputs are registered or decoded from the registered state.
- Reset value of every output is 0. State resets to IDLE; mask_q, timer and step counter reset to 0.
- Reset mid-operation: on the next edge every output is 0, so halt is released immediately.
- Latency, start accepted at edge 0 with cores already halted:
  - HALT in cycle 1.
  - RESTORE_CSR in cycle 2.
  - RESTORE_PC in cycle 3.
  - RESTORE_RF in cycles 4..3+NumRegs/RfWritePorts.
  - RESUME, then WAIT_RUN.
  - done_o in the cycle after WAIT_RUN observes all masked cores running.
- With the defaults and immediate responses: RESUME in cycle 20, WAIT_RUN in cycle 21, done_o in cycle 22.
- Timeout: timeout_o is high in the first IDLE cycle after HaltTimeout+1 waiting cycles.

## Structure
- Add to the shared cluster package:
  - typedef enum recovery_state_e (the seven states).
  - localparam RecoveryHaltTimeout=255.
  - localparam RecoveryRfPorts=2.
- Single module; the step counter and the timer are local. No sub-module is needed.
- Elaboration assertion: NumRegs % RfWritePorts == 0.

## Test plan
- Nominal: mask=8'h05, cores halt after 3 cycles, defaults.
  - debug_halt_o=8'h05 from cycle 1.
  - 16 RF cycles with port addresses (0,1)…(30,31).
  - debug_resume_o=8'h05 for exactly one cycle.
  - done_o a single pulse; no timeout.
- Halt timeout: mask=8'h01, core never halts.
  - timeout_o pulse at cycle 257.
  - No csr_restore_o, pc_restore_o or rf_we_o ever.
  - debug_halt_o=0 afterwards.
- Port count: RfWritePorts=4, NumRegs=32.
  - Exactly 8 RF cycles.
  - Cycle k addresses 4k..4k+3.
- Start filtering:
  - start_i with mask 0 → no state change.
  - start_i pulsed during RESTORE_RF → ignored; the sequence completes exactly once.
- Reset mid-RESTORE_RF at step 5: all outputs 0 on the next edge; a new start then runs a full 16-step restore.
- Resume timeout: a core stays halted after RESUME → timeout_o after 256 WAIT_RUN cycles, no done_o.
